// File: rtl/series_pkg.sv
// Shared constants and arithmetic helpers for the series-evaluation datapath.
//   FRAC / ONE : default fixed-point format (Q2.14) and its unit value
//   coef(i)    : series coefficient 1/(i+1) in fixed point, floored
//   sat(v, w)  : clamp a wide signed value into the signed w-bit range
package series_pkg;

  localparam int unsigned FRAC = 14;
  localparam int unsigned ONE  = 32'd1 << FRAC;

  // 1/(i+1) scaled by 2^frac; integer division floors for these positive operands
  function automatic int coef(input int unsigned i, input int unsigned frac);
    return int'((32'd1 << frac) / (i + 32'd1));
  endfunction

  // Saturating clamp; callers truncate the 64-bit result to w bits afterwards
  function automatic logic signed [63:0] sat(input logic signed [63:0] v,
                                             input int unsigned w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 32'd1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 32'd1));
    if (v > hi) begin
      return hi;
    end else if (v < lo) begin
      return lo;
    end
    return v;
  endfunction

endpackage

// File: rtl/term_counter.sv
// Term index counter for the series controller interface.
//   clk, rst : clock, async active-low reset
//   z_c      : clear counter (wins over en_c)
//   en_c     : advance counter, wrapping after N_TERMS-1
//   c        : current term index
//   co       : c is on the last term (combinational from c)
module term_counter #(
  parameter  int unsigned N_TERMS = 8,
  localparam int unsigned CW      = $clog2(N_TERMS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          z_c,
  input  logic          en_c,
  output logic [CW-1:0] c,
  output logic          co
);

  localparam logic [CW-1:0] LAST = CW'(N_TERMS - 1);

  // Explicit wrap at LAST so non-power-of-two term counts also cycle correctly
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      c <= '0;
    end else if (z_c) begin
      c <= '0;
    end else if (en_c) begin
      c <= (c == LAST) ? '0 : c + CW'(1);
    end
  end

  assign co = (c == LAST);

endmodule

// File: rtl/series_datapath.sv
// Fixed-point datapath for series evaluation driven by an external controller.
// Holds operand x, x^2, current term t, accumulator r and term index c.
//   clk, rst     : clock, async active-low reset
//   x_in, ld_x   : operand load (x and its saturated square)
//   init_t, ld_t : term set to ONE / advance t <= t * op * 1/(c+1)
//   init_r, ld_r : accumulator clear / r <= r +/- t
//   z_c, en_c    : term counter clear / increment
//   s_mux        : multiplier operand, 0 = x, 1 = x^2
//   s_signop     : accumulate direction, 0 = add, 1 = subtract
//   co           : counter at last term (combinational)
//   flag         : t is zero (combinational)
//   result       : accumulator r
module series_datapath #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned FRAC    = 14,
  parameter int unsigned N_TERMS = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [WIDTH-1:0] x_in,
  input  logic                    ld_x,
  input  logic                    init_t,
  input  logic                    ld_t,
  input  logic                    init_r,
  input  logic                    ld_r,
  input  logic                    z_c,
  input  logic                    en_c,
  input  logic                    s_mux,
  input  logic                    s_signop,
  output logic                    co,
  output logic                    flag,
  output logic signed [WIDTH-1:0] result
);

  import series_pkg::*;

  localparam int unsigned CW = $clog2(N_TERMS);
  localparam int unsigned PW = 2 * WIDTH + 2;
  localparam int unsigned AW = WIDTH + 1;
  localparam logic signed [WIDTH-1:0] T_ONE = WIDTH'(32'd1 << FRAC);

  logic signed [WIDTH-1:0] x;
  logic signed [WIDTH-1:0] xsq;
  logic signed [WIDTH-1:0] t;
  logic signed [WIDTH-1:0] r;
  logic        [CW-1:0]    c;

  logic signed [PW-1:0]    xin_e;
  logic signed [PW-1:0]    sq_full;
  logic signed [PW-1:0]    t_e;
  logic signed [PW-1:0]    op_e;
  logic signed [PW-1:0]    p_full;
  logic signed [PW-1:0]    p_e;
  logic signed [PW-1:0]    coef_e;
  logic signed [PW-1:0]    tn_full;
  logic signed [WIDTH-1:0] op;
  logic signed [WIDTH-1:0] xsq_n;
  logic signed [WIDTH-1:0] p;
  logic signed [WIDTH-1:0] t_n;
  logic signed [AW-1:0]    acc;
  logic signed [WIDTH-1:0] r_n;

  term_counter #(.N_TERMS(N_TERMS)) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .z_c  (z_c),
    .en_c (en_c),
    .c    (c),
    .co   (co)
  );

  // Next-value arithmetic; products sized so they never overflow before the shift
  always_comb begin
    xin_e   = PW'(x_in);
    sq_full = (xin_e * xin_e) >>> FRAC;
    xsq_n   = WIDTH'(sat(64'(sq_full), WIDTH));

    op      = s_mux ? xsq : x;
    t_e     = PW'(t);
    op_e    = PW'(op);
    p_full  = (t_e * op_e) >>> FRAC;
    p       = WIDTH'(sat(64'(p_full), WIDTH));

    // Coefficient indexed by c before any same-edge counter update
    p_e     = PW'(p);
    coef_e  = PW'(coef(32'(c), FRAC));
    tn_full = (p_e * coef_e) >>> FRAC;
    t_n     = WIDTH'(sat(64'(tn_full), WIDTH));

    acc     = s_signop ? (AW'(r) - AW'(t)) : (AW'(r) + AW'(t));
    r_n     = WIDTH'(sat(64'(acc), WIDTH));
  end

  // Data registers; the init commands take priority over their load counterparts
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x   <= '0;
      xsq <= '0;
      t   <= '0;
      r   <= '0;
    end else begin
      if (ld_x) begin
        x   <= x_in;
        xsq <= xsq_n;
      end
      if (init_t) begin
        t <= T_ONE;
      end else if (ld_t) begin
        t <= t_n;
      end
      if (init_r) begin
        r <= '0;
      end else if (ld_r) begin
        r <= r_n;
      end
    end
  end

  assign flag   = (t == '0);
  assign result = r;

endmodule

// File: tb/tb_series_datapath.sv
module tb_series_datapath;

  localparam logic [8:0] C_LDX = 9'h100;
  localparam logic [8:0] C_IT  = 9'h080;
  localparam logic [8:0] C_LT  = 9'h040;
  localparam logic [8:0] C_IR  = 9'h020;
  localparam logic [8:0] C_LR  = 9'h010;
  localparam logic [8:0] C_Z   = 9'h008;
  localparam logic [8:0] C_EN  = 9'h004;
  localparam logic [8:0] C_MUX = 9'h002;
  localparam logic [8:0] C_SUB = 9'h001;
  localparam int         NV    = 34;

  typedef struct {
    logic signed [15:0] x_in;
    logic [8:0]         cmd;
    logic signed [15:0] ex;
    logic signed [15:0] exsq;
    logic signed [15:0] et;
    logic signed [15:0] er;
    logic [2:0]         ec;
  } vec_t;

  logic               clk;
  logic               rst;
  logic signed [15:0] x_in;
  logic               ld_x, init_t, ld_t, init_r, ld_r, z_c, en_c, s_mux, s_signop;
  logic               co, flag;
  logic signed [15:0] result;

  int   n_cmp;
  int   n_bad;
  vec_t vecs[NV];
  vec_t sb[$];
  vec_t e;

  series_datapath #(.WIDTH(16), .FRAC(14), .N_TERMS(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .x_in     (x_in),
    .ld_x     (ld_x),
    .init_t   (init_t),
    .ld_t     (ld_t),
    .init_r   (init_r),
    .ld_r     (ld_r),
    .z_c      (z_c),
    .en_c     (en_c),
    .s_mux    (s_mux),
    .s_signop (s_signop),
    .co       (co),
    .flag     (flag),
    .result   (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input int xi, input logic [8:0] cmd, input int ex, input int exsq,
                              input int et, input int er, input int ec);
    vec_t v;
    v.x_in = 16'(xi);
    v.cmd  = cmd;
    v.ex   = 16'(ex);
    v.exsq = 16'(exsq);
    v.et   = 16'(et);
    v.er   = 16'(er);
    v.ec   = 3'(ec);
    return v;
  endfunction

  task automatic drive(input int xi, input logic [8:0] cmd);
    x_in     = 16'(xi);
    ld_x     = cmd[8];
    init_t   = cmd[7];
    ld_t     = cmd[6];
    init_r   = cmd[5];
    ld_r     = cmd[4];
    z_c      = cmd[3];
    en_c     = cmd[2];
    s_mux    = cmd[1];
    s_signop = cmd[0];
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input int ex, input int exsq, input int et,
                         input int er, input int ec);
    chk({tag, " x"},      int'(dut.x), ex);
    chk({tag, " xsq"},    int'(dut.xsq), exsq);
    chk({tag, " t"},      int'(dut.t), et);
    chk({tag, " result"}, int'(result), er);
    chk({tag, " c"},      int'(dut.c), ec);
    chk({tag, " co"},     int'(co), (ec == 7) ? 1 : 0);
    chk({tag, " flag"},   int'(flag), (et == 0) ? 1 : 0);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    drive(0, 9'h000);

    // Hand-computed vectors, Q2.14 (ONE = 16384)
    vecs[0]  = mk(8192,   C_LDX,               8192,   4096,  0,     0,      0);
    vecs[1]  = mk(-16384, C_LDX,               -16384, 16384, 0,     0,      0);
    vecs[2]  = mk(8192,   C_LDX | C_IT | C_Z,  8192,   4096,  16384, 0,      0);
    vecs[3]  = mk(0,      C_LT | C_EN,         8192,   4096,  8192,  0,      1);
    vecs[4]  = mk(0,      C_LT | C_EN,         8192,   4096,  2048,  0,      2);
    vecs[5]  = mk(0,      C_IT | C_IR,         8192,   4096,  16384, 0,      2);
    vecs[6]  = mk(0,      C_LR,                8192,   4096,  16384, 16384,  2);
    vecs[7]  = mk(0,      C_LR,                8192,   4096,  16384, 32767,  2);
    vecs[8]  = mk(0,      C_LR | C_SUB,        8192,   4096,  16384, 16383,  2);
    vecs[9]  = mk(0,      C_LR | C_LT | C_MUX, 8192,   4096,  1365,  32767,  2);
    vecs[10] = mk(0,      C_LR | C_SUB,        8192,   4096,  1365,  31402,  2);
    vecs[11] = mk(-8192,  C_LDX,               -8192,  4096,  1365,  31402,  2);
    vecs[12] = mk(0,      C_LT,                -8192,  4096,  -228,  31402,  2);
    vecs[13] = mk(0,      C_LR | C_SUB,        -8192,  4096,  -228,  31630,  2);
    vecs[14] = mk(0,      C_LR | C_SUB,        -8192,  4096,  -228,  31858,  2);
    vecs[15] = mk(0,      C_IT | C_IR,         -8192,  4096,  16384, 0,      2);
    vecs[16] = mk(0,      C_LR | C_SUB,        -8192,  4096,  16384, -16384, 2);
    vecs[17] = mk(0,      C_LR | C_SUB,        -8192,  4096,  16384, -32768, 2);
    vecs[18] = mk(0,      C_LR | C_SUB,        -8192,  4096,  16384, -32768, 2);
    vecs[19] = mk(-32768, C_LDX,               -32768, 32767, 16384, -32768, 2);
    vecs[20] = mk(0,      C_Z,                 -32768, 32767, 16384, -32768, 0);
    for (int k = 1; k <= 7; k++) begin
      vecs[20 + k] = mk(0, C_EN, -32768, 32767, 16384, -32768, k);
    end
    vecs[28] = mk(0,      C_EN,                -32768, 32767, 16384, -32768, 0);
    vecs[29] = mk(0,      C_EN,                -32768, 32767, 16384, -32768, 1);
    vecs[30] = mk(0,      C_Z | C_EN,          -32768, 32767, 16384, -32768, 0);
    vecs[31] = mk(0,      C_LDX | C_IT,        0,      0,     16384, -32768, 0);
    vecs[32] = mk(0,      C_LT,                0,      0,     0,     -32768, 0);
    vecs[33] = mk(0,      C_IT | C_LT,         0,      0,     16384, -32768, 0);

    // Power-up reset
    rst = 1'b1;
    #3 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_all("por", 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;

    // Table: expectation queued at drive time, popped after the sampling edge
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(int'(vecs[i].x_in), vecs[i].cmd);
      sb.push_back(vecs[i]);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk_all($sformatf("vec%0d", i), int'(e.ex), int'(e.exsq), int'(e.et),
              int'(e.er), int'(e.ec));
    end
    chk("sb_empty", sb.size(), 0);

    // Walk the counter to its last value, then reset asynchronously mid-cycle
    @(negedge clk);
    drive(8192, C_LDX | C_EN);
    repeat (7) @(posedge clk);
    #1;
    chk("pre_rst c", int'(dut.c), 7);
    chk("pre_rst co", int'(co), 1);
    chk("pre_rst x", int'(dut.x), 8192);
    drive(8192, C_LDX | C_EN | C_IT);
    #2 rst = 1'b0;
    #1;
    chk_all("async_rst", 0, 0, 0, 0, 0);

    // Reset held across an edge with commands asserted: nothing loads
    @(posedge clk);
    #1;
    chk_all("rst_held", 0, 0, 0, 0, 0);

    // Release between edges; commands take effect on the next rising edge
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_all("rst_rel", 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    chk_all("post_rel", 8192, 4096, 16384, 0, 1);

    drive(0, 9'h000);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
